// File: rtl/bridge_pkg.sv
// Shared constants and state encoding for the frame-memory bridge.
package bridge_pkg;

  localparam logic [15:0] TEMPL_BASE    = 16'h0000;
  localparam logic [15:0] WIND_BASE     = 16'h4000;
  localparam int          NUM_SETS      = 150;
  localparam int          WORDS_PER_SET = 3;
  localparam int          RES_DEPTH     = 512;
  localparam int          RES_AW        = $clog2(RES_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/frame_mem_bridge_result_ram.sv
// Simple dual-port result store: one write port, one read port with a registered output.
module result_ram
  import bridge_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so the tool can map them
  // onto block RAM; their contents after reset are simply undefined.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register only updates on a read, so it holds a prefetched word while stalled.
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/frame_mem_bridge.sv
// Frame-memory bridge: address mapping for controller reads, result capture, and the
// per-frame load / start / compute / drain sequence.
module frame_mem_bridge #(
  parameter int ADDR_W        = 16,
  parameter int NUM_SETS      = 150,
  parameter int WORDS_PER_SET = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rd_wr,
  input  logic              tem_win,
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  input  logic [7:0]        set,
  input  logic [1:0]        wr_index,
  input  logic [31:0]       write_data,
  input  logic              set_done,
  output logic [31:0]       read_data,
  output logic              ready_2_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              frame_loaded,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_last,
  output logic              busy,
  output logic              err_overrun
);

  import bridge_pkg::state_e, bridge_pkg::ST_IDLE, bridge_pkg::ST_START;
  import bridge_pkg::ST_COMPUTE, bridge_pkg::ST_DRAIN;
  import bridge_pkg::TEMPL_BASE, bridge_pkg::WIND_BASE, bridge_pkg::RES_DEPTH;

  localparam int                  RES_AW    = bridge_pkg::RES_AW;
  localparam int                  RES_WORDS = NUM_SETS * WORDS_PER_SET;
  localparam logic [RES_AW-1:0]   RES_CNT   = RES_AW'(RES_WORDS);
  localparam logic [RES_AW-1:0]   LAST_IDX  = RES_AW'(RES_WORDS - 1);
  localparam logic [7:0]          SET_MAX   = 8'(NUM_SETS);
  localparam logic [1:0]          WPS       = 2'(WORDS_PER_SET);

  state_e state_q, state_d;

  logic [31:0]       read_data_q;
  logic              err_overrun_q;
  logic [RES_AW-1:0] wr_cnt_q;
  logic              in_compute;

  logic [RES_AW-1:0] set_m1, wr_idx;
  logic              wr_ok, wr_en;

  logic [RES_AW-1:0] rd_ptr_q, ram_raddr;
  logic              ram_vld_q, ram_last_q;
  logic [31:0]       ram_rdata;
  logic              res_valid_q, res_last_q;
  logic [31:0]       res_data_q;
  logic              start_issue, drain_issue, ram_re, load_out;

  assign in_compute = (state_q == ST_COMPUTE);

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame_loaded) state_d = ST_START;
      ST_START:   state_d = ST_COMPUTE;
      ST_COMPUTE: if (set_done) state_d = ST_DRAIN;
      ST_DRAIN:   if (res_valid_q && res_ready && res_last_q) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign mem_addr = ADDR_W'((tem_win ? WIND_BASE : TEMPL_BASE) + {2'b00, row, col});
  assign mem_rd   = in_compute & req & ~rd_wr;

  // Sets count from 1, so set 0 wraps set_m1 to all ones; wr_ok gates that case out.
  assign set_m1 = RES_AW'(set) - RES_AW'(1);
  assign wr_idx = RES_AW'(set_m1 * RES_AW'(WORDS_PER_SET)) + RES_AW'(wr_index);
  assign wr_ok  = (wr_index < WPS) && (set != 8'd0) && (set <= SET_MAX);
  assign wr_en  = in_compute & req & rd_wr & wr_ok;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      read_data_q   <= '0;
      err_overrun_q <= 1'b0;
      wr_cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (mem_rd) read_data_q <= mem_rdata;
      if (frame_loaded && (state_q != ST_IDLE)) err_overrun_q <= 1'b1;
      if (state_q == ST_START) wr_cnt_q <= '0;
      else if (wr_en)          wr_cnt_q <= wr_cnt_q + RES_AW'(1);
    end
  end

  // Entry 0 is fetched on the set_done cycle itself; later entries whenever the RAM
  // output register is empty or being emptied into the output stage.
  assign load_out    = ram_vld_q & (~res_valid_q | res_ready);
  assign start_issue = in_compute & set_done;
  assign drain_issue = (state_q == ST_DRAIN) & (rd_ptr_q < RES_CNT) & (~ram_vld_q | load_out);
  assign ram_re      = start_issue | drain_issue;
  assign ram_raddr   = start_issue ? '0 : rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
    end else begin
      if (ram_re)                    rd_ptr_q <= ram_raddr + RES_AW'(1);
      else if (state_q != ST_DRAIN)  rd_ptr_q <= '0;

      if (ram_re)                              ram_vld_q <= 1'b1;
      else if (load_out || state_q != ST_DRAIN) ram_vld_q <= 1'b0;

      if (ram_re) ram_last_q <= (ram_raddr == LAST_IDX);

      if (state_q != ST_DRAIN) begin
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
      end else if (load_out) begin
        res_valid_q <= 1'b1;
        res_data_q  <= ram_rdata;
        res_last_q  <= ram_last_q;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
      end
    end
  end

  result_ram #(
    .DEPTH (RES_DEPTH),
    .DW    (32)
  ) u_result_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_idx),
    .wdata_i (write_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign read_data     = read_data_q;
  assign ready_2_start = (state_q == ST_START);
  assign busy          = (state_q != ST_IDLE);
  assign err_overrun   = err_overrun_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_last      = res_last_q;

endmodule

// File: doc/frame_mem_bridge.md
# frame_mem_bridge

Memory-side neighbour of the NCC frame controller. It turns the controller's request fields (`req`, `rd_wr`, `tem_win`, `row`, `col`, `set`, `wr_index`) into frame-memory addresses and returns `read_data`. It also captures the three result words written per set into a local result RAM, and sequences each frame: host load, then `ready_2_start` pulse, then compute, then result drain.

## Interface
Parameters:
- `ADDR_W`, 16, frame-memory address width.
- `NUM_SETS`, 150, sets per frame.
- `WORDS_PER_SET`, 3, result words per set.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`, `rd_wr`, `tem_win`  in  1 each  controller request, 0=read/1=write, 0=template/1=window.
- `row`, `col`  in  7 each  patch coordinates.
- `set`  in  8  controller set counter, 1..`NUM_SETS` during writes.
- `wr_index`  in  2  result word index 0..2.
- `write_data`  in  32  result word.
- `set_done`  in  1  frame-complete pulse from the controller.
- `read_data`  out  32  registered memory read data.
- `ready_2_start`  out  1  start pulse to the controller.
- `mem_addr`  out  `ADDR_W`  frame-memory address.
- `mem_rd`  out  1  frame-memory read strobe.
- `mem_rdata`  in  32  frame memory, 1-cycle read latency.
- `frame_loaded`  in  1  host pulse: frame memory is filled.
- `res_valid`, `res_ready`, `res_data[31:0]`, `res_last`  result stream out to the host; `res_ready` is the only input.
- `busy`  out  1  high in any state other than IDLE.
- `err_overrun`  out  1  sticky; set by `frame_loaded` outside IDLE.

## Operation
- FSM states: IDLE → START → COMPUTE → DRAIN → IDLE.
- **IDLE:** waits for `frame_loaded`, then moves to START.
- **START:** single cycle with `ready_2_start`=1, then COMPUTE.
- **COMPUTE:** services memory. Moves to DRAIN on `set_done`.
- **DRAIN:** streams `NUM_SETS*WORDS_PER_SET` = 450 words. Returns to IDLE after the handshake on the `res_last` word.
- **Read address:** `mem_addr = (tem_win ? WIND_BASE : TEMPL_BASE) + {row,col}`, where TEMPL_BASE=16'h0000 and WIND_BASE=16'h4000.
  - `mem_rd = req & ~rd_wr`, gated to COMPUTE.
  - `mem_addr` is combinational from the inputs.
- **Result write:** when `req & rd_wr` in COMPUTE, write `write_data` to result RAM entry `(set-1)*3 + wr_index`.
  - Index is 9 bits; arithmetic is unsigned.
  - Writes with `wr_index`=3, `set`=0 or `set`>`NUM_SETS` are dropped.
- **Write counter:** a 9-bit count of accepted writes is cleared at START. Unwritten entries drain as stale data; no error is raised.
- **Drain:** RAM read pointer 0..449 with prefetch into an output register.
  - `res_data` and `res_last` hold stable while `res_valid & ~res_ready`.
  - `res_last`=1 only on entry 449.
- `frame_loaded` in any non-IDLE state is ignored and sets `err_overrun`.
- Requests outside COMPUTE: `mem_rd`=0 and writes are dropped.
- `set_done` outside COMPUTE is ignored.

## Timing
- **Reset values:** FSM=IDLE, `read_data`=0, `ready_2_start`=0, `mem_rd`=0, `res_valid`=0, `res_data`=0, `res_last`=0, `busy`=0, `err_overrun`=0, pointers and counters 0.
- `mem_addr` is combinational, so it is 0 under reset only when its inputs are.
- **Read latency:** request in cycle t, `read_data` valid in t+1 (registered `mem_rdata`). `read_data` holds its last value when no read occurs.
- **Start:** `frame_loaded` sampled at edge t gives `ready_2_start`=1 for exactly cycle t+1.
- **Drain start:** `set_done` at edge t gives first `res_valid` at t+2 (one RAM read cycle).
- **Drain throughput:** one word per cycle while `res_ready`=1, so the last word is accepted at earliest t+451. `res_valid` drops the cycle after the last handshake.
- A result write and a drain read never coincide, because the FSM states are exclusive.
- **Reset mid-operation:** async return to IDLE, all outputs go to their reset values, and RAM contents are don't-care.

## Structure
- `bridge_pkg` holds `TEMPL_BASE`, `WIND_BASE`, `NUM_SETS`, `WORDS_PER_SET`, `RES_DEPTH`=512, and the state enum.
- Sub-module `result_ram`: 512×32 simple dual-port, one write port and one read port with 1-cycle registered read. It has no reset and is inferable as block RAM.
- Top level contains the FSM, address mapping, index arithmetic, drain pointer and the output skid register.

## Test plan
- **Address map:** in COMPUTE, read with `tem_win`=1, `row`=3, `col`=5 → `mem_addr`=16'h4185, `mem_rd`=1. Drive `mem_rdata`=32'hDEADBEEF in that cycle → `read_data`=32'hDEADBEEF on the next cycle.
- **Start sequencing:** `frame_loaded` pulse → `ready_2_start` high exactly one cycle and `busy`=1. A second `frame_loaded` → `err_overrun`=1 and no second start.
- **Full frame:** write `{set,wr_index}` patterns for sets 1..150, then `set_done`. Drain returns 450 words in order with entry k = pattern(k/3+1, k%3), and `res_last` only on word 449.
- **Backpressure:** random `res_ready` at 30% duty during drain → no lost or duplicated words, and `res_data` stays stable while stalled.
- **Illegal writes:** writes with `wr_index`=3, with `set`=0, and during IDLE → RAM unchanged and drain shows the prior contents.
- **Reset mid-drain:** assert `rst_n`=0 at word 200 → `res_valid`=0 asynchronously and FSM=IDLE. A new frame then starts normally.
